packet_validator: RTL and testbench

Parametrised frame receiver and checksum validator sitting between the byte-level serial receiver and the output port registers. It assembles bytes delivered by a strobe into a frame of sync, address, `N_PORTS` payload bytes and an XOR checksum. It drops frames that are foreign or stalled, and updates all output ports atomically on a valid frame. It drives status LEDs for good frames, checksum errors and timeouts.

---
 rtl/pv_pkg.sv | 23 ++
 rtl/pulse_stretch.sv | 43 ++++
 rtl/packet_validator.sv | 183 ++++++++++++++++++
 tb/tb_packet_validator.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pv_pkg.sv
// Shared types and sizing helpers for the packet validator.
// Frame layout: sync, address, N payload bytes, XOR checksum.
package pv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_PAYLOAD,
    S_CSUM,
    S_SKIP,
    S_CHECK
  } pv_state_t;

  function automatic int frame_len(input int n_ports);
    return n_ports + 3;
  endfunction

  // Bits needed for a counter that must hold values 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Retriggerable one-shot: output goes high on the edge that samples trig_i
// and stays high for exactly HOLD cycles after the most recent trigger.
module pulse_stretch
  import pv_pkg::*;
#(
  parameter int HOLD = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic trig_i,
  output logic pulse_o
);

  localparam int CW = cnt_w(HOLD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;

  always_comb begin
    cnt_d = cnt_q;
    out_d = 1'b0;
    if (trig_i) begin
      cnt_d = CW'(HOLD - 1);
      out_d = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      out_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign pulse_o = out_q;

endmodule

// File: rtl/packet_validator.sv
// Strobed byte receiver that assembles addressed frames, validates the XOR
// checksum and updates all output ports atomically on a good frame.
module packet_validator
  import pv_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                N_PORTS     = 2,
  parameter logic [DATA_W-1:0] SYNC_BYTE   = 8'hA5,
  parameter logic [DATA_W-1:0] DEV_ADDR    = 8'h01,
  parameter int                TIMEOUT_CYC = 1000,
  parameter int                LED_HOLD    = 50_000_000
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [DATA_W-1:0]           BYTE_IN,
  input  logic                        BYTE_STB,
  output logic [N_PORTS*DATA_W-1:0]   PORT_OUT,
  output logic                        PORT_UPD,
  output logic                        LED_OK,
  output logic                        LED_ERR,
  output logic                        LED_TMO
);

  localparam int FRAME_LEN = frame_len(N_PORTS);
  // A foreign frame still carries payload + checksum after its address byte.
  localparam int SKIP_LAST = FRAME_LEN - 3;
  localparam int IDX_W     = cnt_w(FRAME_LEN);
  localparam int GAP_W     = cnt_w(TIMEOUT_CYC);

  pv_state_t                    state_q, state_d;
  logic                         stb_q;
  logic                         byte_ev;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [DATA_W-1:0]            xor_q, xor_d;
  logic [DATA_W-1:0]            csum_q, csum_d;
  logic [GAP_W-1:0]             gap_q, gap_d;
  logic [N_PORTS*DATA_W-1:0]    port_q, port_d;
  logic                         upd_q, upd_d;
  logic                         err_q, err_d;
  logic                         tmo_q, tmo_d;
  logic                         ok_trig;
  logic                         buf_wr;
  logic [DATA_W-1:0]            buf_q [N_PORTS];
  logic [DATA_W-1:0]            buf_d [N_PORTS];
  logic [N_PORTS*DATA_W-1:0]    buf_flat;
  logic                         frame_active;

  assign byte_ev = BYTE_STB & ~stb_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) stb_q <= 1'b0;
    else        stb_q <= BYTE_STB;
  end

  // Payload buffer: one write-enabled slot per port byte.
  genvar gi;
  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_buf
      assign buf_d[gi] = (buf_wr && idx_q == IDX_W'(gi)) ? BYTE_IN : buf_q[gi];
      assign buf_flat[gi*DATA_W +: DATA_W] = buf_q[gi];
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N_PORTS; i++) buf_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) buf_q[i] <= buf_d[i];
    end
  end

  assign frame_active = (state_q == S_ADDR) || (state_q == S_PAYLOAD) ||
                        (state_q == S_CSUM) || (state_q == S_SKIP);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    xor_d   = xor_q;
    csum_d  = csum_q;
    gap_d   = '0;
    port_d  = port_q;
    upd_d   = 1'b0;
    err_d   = err_q;
    tmo_d   = tmo_q;
    ok_trig = 1'b0;
    buf_wr  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (byte_ev && BYTE_IN == SYNC_BYTE) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (byte_ev) begin
          idx_d   = '0;
          xor_d   = '0;
          state_d = (BYTE_IN == DEV_ADDR) ? S_PAYLOAD : S_SKIP;
        end
      end
      S_PAYLOAD: begin
        if (byte_ev) begin
          buf_wr = 1'b1;
          xor_d  = xor_q ^ BYTE_IN;
          if (idx_q == IDX_W'(N_PORTS - 1)) state_d = S_CSUM;
          else                              idx_d   = idx_q + IDX_W'(1);
        end
      end
      S_CSUM: begin
        if (byte_ev) begin
          csum_d  = BYTE_IN;
          state_d = S_CHECK;
        end
      end
      S_SKIP: begin
        if (byte_ev) begin
          if (idx_q == IDX_W'(SKIP_LAST)) state_d = S_IDLE;
          else                            idx_d   = idx_q + IDX_W'(1);
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if (xor_q == csum_q) begin
          port_d  = buf_flat;
          upd_d   = 1'b1;
          err_d   = 1'b0;
          tmo_d   = 1'b0;
          ok_trig = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A strobe landing on the expiry cycle keeps the frame alive.
    if (frame_active && !byte_ev) begin
      if (gap_q == GAP_W'(TIMEOUT_CYC - 1)) begin
        state_d = S_IDLE;
        tmo_d   = 1'b1;
      end else begin
        gap_d = gap_q + GAP_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      xor_q   <= '0;
      csum_q  <= '0;
      gap_q   <= '0;
      port_q  <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      xor_q   <= xor_d;
      csum_q  <= csum_d;
      gap_q   <= gap_d;
      port_q  <= port_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  pulse_stretch #(
    .HOLD (LED_HOLD)
  ) u_led_ok (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .trig_i  (ok_trig),
    .pulse_o (LED_OK)
  );

  assign PORT_OUT = port_q;
  assign PORT_UPD = upd_q;
  assign LED_ERR  = err_q;
  assign LED_TMO  = tmo_q;

endmodule

// File: tb/tb_packet_validator.sv
// Self-checking bench for packet_validator: directed scenarios plus random
// frames, checked against a byte-queue frame model.
module tb_packet_validator;

  localparam int N       = 2;
  localparam int W       = 8;
  localparam int FLEN    = N + 3;
  localparam int TMO_CYC = 1000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   byte_in = '0;
  logic           byte_stb = 1'b0;
  logic [N*W-1:0] port_out;
  logic           port_upd, led_ok, led_err, led_tmo;

  int checks = 0;
  int errors = 0;
  int upd_seen = 0;

  // Model state
  logic [W-1:0]   frm[$];
  logic [N*W-1:0] m_port;
  logic           m_ok, m_err, m_tmo;
  int             m_upd = 0;

  always #5 clk = ~clk;

  packet_validator dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .BYTE_IN  (byte_in),
    .BYTE_STB (byte_stb),
    .PORT_OUT (port_out),
    .PORT_UPD (port_upd),
    .LED_OK   (led_ok),
    .LED_ERR  (led_err),
    .LED_TMO  (led_tmo)
  );

  always @(negedge clk) if (port_upd) upd_seen++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    frm.delete();
    m_port = '0; m_ok = 0; m_err = 0; m_tmo = 0;
  endtask

  task automatic model_byte(input logic [W-1:0] b);
    logic [W-1:0] x;
    if (frm.size() == 0 && b != 8'hA5) return;
    frm.push_back(b);
    if (frm.size() == FLEN) begin
      if (frm[1] == 8'h01) begin
        x = '0;
        for (int i = 0; i < N; i++) x ^= frm[2+i];
        if (x == frm[N+2]) begin
          for (int i = 0; i < N; i++) m_port[i*W +: W] = frm[2+i];
          m_ok = 1; m_err = 0; m_tmo = 0; m_upd++;
        end else begin
          m_err = 1;
        end
      end
      frm.delete();
    end
  endtask

  task automatic model_timeout();
    if (frm.size() != 0) begin
      frm.delete();
      m_tmo = 1;
    end
  endtask

  // Rising strobe at a negedge, held for 'hold' cycles, then 'gap' idle cycles.
  task automatic send_byte(input logic [W-1:0] b, input int hold, input int gap);
    @(negedge clk);
    byte_in  = b;
    byte_stb = 1'b1;
    model_byte(b);
    repeat (hold) @(negedge clk);
    byte_stb = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [W-1:0] b0, b1, b2, b3, b4, input int hold);
    send_byte(b0, hold, 10 - (hold % 10 == 0 ? 1 : hold % 10));
    send_byte(b1, hold, 9);
    send_byte(b2, hold, 9);
    send_byte(b3, hold, 9);
    send_byte(b4, hold, 9);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({port_out, port_upd, led_ok, led_err, led_tmo} !== '0) begin
      errors++;
      $display("FAIL reset_state: got port=%h upd=%b ok=%b err=%b tmo=%b, want all 0",
               port_out, port_upd, led_ok, led_err, led_tmo);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_good_frame();
    int u0;
    u0 = upd_seen;
    send_byte(8'hA5, 1, 9);
    send_byte(8'h01, 1, 9);
    send_byte(8'h3C, 1, 9);
    send_byte(8'h5A, 1, 9);
    send_byte(8'h66, 1, 0);
    // One cycle after the checksum edge: not yet visible
    checks++;
    if (port_out !== 16'h0000 || port_upd !== 1'b0) begin
      errors++;
      $display("FAIL good_early: got port=%h upd=%b, want 0000/0", port_out, port_upd);
    end
    @(negedge clk);
    checks++;
    if (port_out !== 16'h5A3C || port_upd !== 1'b1 || led_ok !== 1'b1 || led_err !== 1'b0) begin
      errors++;
      $display("FAIL good_update: got port=%h upd=%b ok=%b err=%b, want 5a3c/1/1/0",
               port_out, port_upd, led_ok, led_err);
    end
    @(negedge clk);
    checks++;
    if (port_upd !== 1'b0 || upd_seen - u0 != 1) begin
      errors++;
      $display("FAIL good_pulse: got upd=%b pulses=%0d, want 0 and 1 pulse", port_upd, upd_seen - u0);
    end
    repeat (8) @(negedge clk);
    $display("test_good_frame port=%h", port_out);
  endtask

  task automatic test_bad_csum();
    int u0;
    u0 = upd_seen;
    send_frame(8'hA5, 8'h01, 8'h3C, 8'h5A, 8'h67, 1);
    checks++;
    if (led_err !== 1'b1 || port_out !== 16'h5A3C || upd_seen != u0) begin
      errors++;
      $display("FAIL bad_csum: got err=%b port=%h pulses=%0d, want 1/5a3c/0",
               led_err, port_out, upd_seen - u0);
    end
    send_frame(8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 1);
    checks++;
    if (led_err !== 1'b0 || port_out !== 16'h2211 || upd_seen != u0 + 1) begin
      errors++;
      $display("FAIL bad_then_good: got err=%b port=%h pulses=%0d, want 0/2211/1",
               led_err, port_out, upd_seen - u0);
    end
    $display("test_bad_csum port=%h err=%b", port_out, led_err);
  endtask

  task automatic test_foreign_addr();
    int u0;
    u0 = upd_seen;
    send_frame(8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 1);
    checks++;
    if ({port_out, led_ok, led_err, led_tmo} !== {16'h2211, 3'b100} || upd_seen != u0) begin
      errors++;
      $display("FAIL foreign_skip: got port=%h ok/err/tmo=%b%b%b pulses=%0d, want 2211/100/0",
               port_out, led_ok, led_err, led_tmo, upd_seen - u0);
    end
    send_frame(8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 1);
    checks++;
    if (port_out !== 16'h0201 || upd_seen != u0 + 1) begin
      errors++;
      $display("FAIL after_skip: got port=%h pulses=%0d, want 0201/1", port_out, upd_seen - u0);
    end
    $display("test_foreign_addr port=%h", port_out);
  endtask

  task automatic test_timeout();
    send_byte(8'hA5, 1, 9);
    send_byte(8'h01, 1, 9);
    send_byte(8'h3C, 1, 9);
    repeat (TMO_CYC + 1) @(negedge clk);
    model_timeout();
    checks++;
    if (led_tmo !== 1'b1 || port_out !== 16'h0201) begin
      errors++;
      $display("FAIL timeout: got tmo=%b port=%h, want 1/0201", led_tmo, port_out);
    end
    send_frame(8'hA5, 8'h01, 8'h3C, 8'h5A, 8'h66, 1);
    checks++;
    if (led_tmo !== 1'b0 || port_out !== 16'h5A3C) begin
      errors++;
      $display("FAIL timeout_recover: got tmo=%b port=%h, want 0/5a3c", led_tmo, port_out);
    end
    $display("test_timeout tmo=%b port=%h", led_tmo, port_out);
  endtask

  task automatic test_held_strobe();
    int u0;
    u0 = upd_seen;
    send_byte(8'h00, 30, 9);
    send_byte(8'hFF, 30, 9);
    send_frame(8'hA5, 8'h01, 8'hC3, 8'h81, 8'h42, 30);
    checks++;
    if (port_out !== 16'h81C3 || upd_seen != u0 + 1 || led_err !== 1'b0) begin
      errors++;
      $display("FAIL held_strobe: got port=%h pulses=%0d err=%b, want 81c3/1/0",
               port_out, upd_seen - u0, led_err);
    end
    $display("test_held_strobe port=%h", port_out);
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'hA5, 1, 9);
    send_byte(8'h01, 1, 9);
    send_byte(8'h3C, 1, 9);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({port_out, port_upd, led_ok, led_err, led_tmo} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got port=%h upd=%b ok=%b err=%b tmo=%b, want all 0",
               port_out, port_upd, led_ok, led_err, led_tmo);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(8'hA5, 8'h01, 8'h3C, 8'h5A, 8'h66, 1);
    checks++;
    if (port_out !== 16'h5A3C || led_ok !== 1'b1 || led_tmo !== 1'b0 || led_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_recover: got port=%h ok=%b err=%b tmo=%b, want 5a3c/1/0/0",
               port_out, led_ok, led_err, led_tmo);
    end
    $display("test_reset_mid_frame port=%h", port_out);
  endtask

  task automatic test_random();
    logic [W-1:0] p0, p1, cs, ad, g;
    int kind;
    for (int t = 0; t < 16; t++) begin
      kind = $urandom_range(0, 3);
      p0 = W'($urandom); p1 = W'($urandom);
      cs = p0 ^ p1;
      ad = 8'h01;
      if (kind == 1) cs = cs ^ W'($urandom_range(1, 255));
      if (kind == 2) begin
        ad = W'($urandom);
        if (ad == 8'h01) ad = 8'h02;
      end
      if (kind == 3) begin
        g = W'($urandom);
        if (g == 8'hA5) g = 8'h00;
        send_byte(g, 1, 9);
      end
      send_frame(8'hA5, ad, p0, p1, cs, 1);
      checks++;
      if ({port_out, led_ok, led_err, led_tmo} !== {m_port, m_ok, m_err, m_tmo} ||
          upd_seen != m_upd) begin
        errors++;
        $display("FAIL random_%0d: got port=%h ok/err/tmo=%b%b%b pulses=%0d, want %h %b%b%b %0d",
                 t, port_out, led_ok, led_err, led_tmo, upd_seen,
                 m_port, m_ok, m_err, m_tmo, m_upd);
      end
      $display("random frame %0d kind=%0d bytes=A5 %h %h %h %h port=%h", t, kind, ad, p0, p1, cs, port_out);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_foreign_addr();
    test_timeout();
    test_held_strobe();
    test_reset_mid_frame();
    // Resynchronise the pulse count with the model after the directed tests.
    m_upd = upd_seen;
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
